// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file.
// The read-side muxes reuse reg_array_t to consume the committed array.
package regfile_pkg;

    localparam int NUM_REGS   = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int ZERO_REG   = 31;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    typedef logic [DATA_WIDTH-1:0]    reg_word_t;
    typedef reg_word_t [NUM_REGS-1:0] reg_array_t;

endpackage

// File: rtl/regfile_write_port_decoder5_32.sv
// 5-to-32 one-hot decoder; produces all zeros while en is low.
module decoder5_32 (
    input  logic        en,
    input  logic [4:0]  addr,
    output logic [31:0] sel
);

    // One-hot select for the addressed register.
    always_comb begin
        sel = 32'd0;
        if (en) begin
            sel = 32'd1 << addr;
        end else begin
            sel = 32'd0;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the register file: one-stage staging register followed by a
// decoded commit into the array. Register ZERO_REG is hardwired to zero.
module regfile_write_port
    import regfile_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_out,
    output logic                                 pend_valid,
    output logic [ADDR_WIDTH-1:0]                pend_addr,
    output logic [DATA_WIDTH-1:0]                pend_data
);

    logic                  pend_valid_r;
    logic [ADDR_WIDTH-1:0] pend_addr_r;
    reg_word_t             pend_data_r;
    logic [NUM_REGS-1:0]   sel_s;
    reg_array_t            regs_s;

    // Staging register: writes to the zero register never become pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= {ADDR_WIDTH{1'b0}};
            pend_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
            pend_valid_r <= 1'b1;
            pend_addr_r  <= wr_addr;
            pend_data_r  <= wr_data;
        end else begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= pend_addr_r;
            pend_data_r  <= pend_data_r;
        end
    end

    decoder5_32 u_decoder (
        .en   (pend_valid_r),
        .addr (pend_addr_r),
        .sel  (sel_s)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_zero
            // The decoder never selects this slot, so the product is always zero.
            assign regs_s[g] = {DATA_WIDTH{1'b0}} & {DATA_WIDTH{sel_s[g]}};
        end else begin : g_word
            reg_word_t word_r;

            // Enabled storage flop loaded by the one-hot commit select.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word_r <= {DATA_WIDTH{1'b0}};
                end else if (sel_s[g]) begin
                    word_r <= pend_data_r;
                end else begin
                    word_r <= word_r;
                end
            end

            assign regs_s[g] = word_r;
        end
    end

    assign regs_out   = regs_s;
    assign pend_valid = pend_valid_r;
    assign pend_addr  = pend_addr_r;
    assign pend_data  = pend_data_r;

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32 x 64-bit register file. Its register array feeds the 32:1 64-bit read muxes.
- Accepts one write request per cycle and decodes the 5-bit address to 32 one-hot enables through a decoder sub-module.
- Commits the write through a one-stage staging register.
- Exposes the committed array as a packed bus, plus the staged (pending) write so the read side can bypass it.
- Register 31 is hardwired zero.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- DATA_WIDTH, 64, register width in bits.
- ADDR_WIDTH, 5, write address width; equals log2(NUM_REGS).
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request, sampled on the rising edge of clk.
- wr_addr  input  ADDR_WIDTH  destination register index.
- wr_data  input  DATA_WIDTH  write data.
- regs_out  output  [NUM_REGS-1:0][DATA_WIDTH-1:0]  committed register array; connects directly to the read muxes.
- pend_valid  output  1  a staged write will commit on the next edge.
- pend_addr  output  ADDR_WIDTH  address of the staged write.
- pend_data  output  DATA_WIDTH  data of the staged write.

Behaviour:
- Reset: asserting reset_n low forces the following immediately, without waiting for clk:
  - every register = 0;
  - pend_valid = 0, pend_addr = 0, pend_data = 0.
- Reset mid-operation: a staged write that has not committed is discarded and never lands.
- Stage capture (edge N):
  - If wr_en = 1 and wr_addr != ZERO_REG: pend_valid <= 1, pend_addr <= wr_addr, pend_data <= wr_data.
  - Otherwise pend_valid <= 0. pend_addr and pend_data hold their values; their contents are don't-care when pend_valid = 0.
- Commit (edge N+1):
  - If pend_valid = 1, the decoder one-hot enable for pend_addr loads pend_data into that register only.
  - All other registers hold.
- Latency: regs_out shows the new value after edge N+1, i.e. 2 edges after the request cycle. The pend_* outputs show it after edge N.
- Throughput: one write per cycle. Back-to-back requests pipeline, so capture of request k+1 and commit of request k happen on the same edge.
- Same address on consecutive cycles: commits occur in request order; the later value wins.
- Zero register:
  - regs_out[ZERO_REG] is constant 0, and the decoder never enables it.
  - A write to ZERO_REG does not set pend_valid.
- wr_en = 0: no state change except pend_valid <= 0.
- All address values are legal because ADDR_WIDTH fully covers NUM_REGS; no out-of-range handling is needed.

Decomposition:
- Shared package regfile_pkg holds:
  - constants NUM_REGS, DATA_WIDTH, ADDR_WIDTH, ZERO_REG;
  - typedef reg_word_t = logic [DATA_WIDTH-1:0];
  - typedef reg_array_t = reg_word_t [NUM_REGS-1:0].
  The read muxes reuse reg_array_t.
- Sub-module decoder5_32: inputs en, addr[4:0]; output one-hot sel[31:0]; all zeros when en = 0. It is instantiated once, driven by pend_valid and pend_addr.
- Register storage is one generate loop of DATA_WIDTH-bit enabled flops, with index ZERO_REG tied to 0.

Test Plan:
- Reset during traffic:
  - Write reg 3 = 0xDEAD_BEEF_0000_0001 and commit it.
  - Request reg 4 = 0x1234; pulse reset_n low between capture and commit.
  - Required: all 32 registers = 0, pend_valid = 0 immediately, reg 4 = 0 after release.
- Single write:
  - wr_en = 1, addr = 5, data = 0x0123_4567_89AB_CDEF at edge 0.
  - Required: pend_valid = 1 and pend_addr = 5 after edge 0; regs_out[5] = 0x0123_4567_89AB_CDEF after edge 1; all other registers unchanged.
- Zero register:
  - Write addr 31, data = all ones.
  - Required: pend_valid stays 0; regs_out[31] = 0 on every cycle.
- Back-to-back, same address:
  - Writes to reg 7 on consecutive cycles with data 0xAA then 0xBB.
  - Required: regs_out[7] = 0xAA after edge 1, 0xBB after edge 2.
- Full sweep:
  - 31 consecutive writes, addr i, data = i * 0x0101_0101_0101_0101 for i = 0..30.
  - Required: each regs_out[i] matches after its commit edge; no writes to neighbouring registers; pend_valid continuously 1 during the burst.
- Idle gap:
  - Write reg 2 = 0x55, then hold wr_en = 0 for 3 cycles.
  - Required: pend_valid = 0 from the edge after the write's commit; regs_out[2] stays 0x55.
